// File: rtl/hazard_tracker.sv
// Pipeline-side state for the hazard unit: PC register, D/E/M/W address and control
// fields, forwarding match vector, pending PC-write flag and saturating event counters.
module hazard_tracker #(
  parameter int AW   = 4,
  parameter int PCW  = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PCW-1:0]  PCNextF,
  output logic [PCW-1:0]  PCF,
  input  logic [AW-1:0]   RA1D,
  input  logic [AW-1:0]   RA2D,
  input  logic [AW-1:0]   WA3D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            PCSrcD,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            flushE,
  output logic [4:0]      match,
  output logic            PCWrPendingF,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic            MemtoRegE,
  output logic            PCSrcW,
  output logic [AW-1:0]   WA3E,
  output logic [AW-1:0]   WA3M,
  output logic [AW-1:0]   WA3W,
  output logic [CNTW-1:0] stallCnt,
  output logic [CNTW-1:0] flushCnt
);

  logic          validD;
  logic [AW-1:0] RA1E, RA2E;
  logic          RegWriteE, PCSrcE;
  logic          MemtoRegM, PCSrcM;
  logic          MemtoRegW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF    <= '0;
      validD <= 1'b0;
    end else begin
      if (!stallF) PCF <= PCNextF;
      if (flushD)       validD <= 1'b0;
      else if (!stallD) validD <= 1'b1;
    end
  end

  // D/E: flushE always wins, which is how a stalled D inserts its bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset || 1'b0) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
    end else if (flushE) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
    end else begin
      RA1E      <= RA1D;
      RA2E      <= RA2D;
      WA3E      <= WA3D;
      RegWriteE <= RegWriteD & validD;
      MemtoRegE <= MemtoRegD & validD;
      PCSrcE    <= PCSrcD & validD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WA3M      <= '0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      PCSrcM    <= 1'b0;
      WA3W      <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      WA3M      <= WA3E;
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      PCSrcM    <= PCSrcE;
      WA3W      <= WA3M;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      PCSrcW    <= PCSrcM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallD && (stallCnt != '1))
        stallCnt <= stallCnt + CNTW'(1);
      if ((flushD || flushE) && (flushCnt != '1))
        flushCnt <= flushCnt + CNTW'(1);
    end
  end

  // R15 reads return the PC, never a forwarded value, so they never match
  always_comb begin
    match        = 5'b00000;
    PCWrPendingF = 1'b0;
    if (!reset) begin
      match[4] = validD & (((RA1D == WA3E) & ~(&RA1D)) | ((RA2D == WA3E) & ~(&RA2D)));
      match[3] = (RA1E == WA3M) & ~(&RA1E);
      match[2] = (RA2E == WA3M) & ~(&RA2E);
      match[1] = (RA1E == WA3W) & ~(&RA1E);
      match[0] = (RA2E == WA3W) & ~(&RA2E);
      PCWrPendingF = (PCSrcD & validD) | PCSrcE | PCSrcM;
    end
  end

  logic unused_ok;
  assign unused_ok = MemtoRegW;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: forwarding, load-use stall, branch flush,
// R15 exclusion, counter saturation and asynchronous reset.
module tb_hazard_tracker;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCNextF, PCF;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD;
  logic        stallF, stallD, flushD, flushE;
  logic [4:0]  match;
  logic        PCWrPendingF, RegWriteM, RegWriteW, MemtoRegE, PCSrcW;
  logic [3:0]  WA3E, WA3M, WA3W;
  logic [3:0]  stallCnt, flushCnt;

  int total = 0;
  int bad   = 0;

  hazard_tracker #(.AW(4), .PCW(32), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .PCNextF(PCNextF), .PCF(PCF),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .match(match), .PCWrPendingF(PCWrPendingF),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCSrcW(PCSrcW),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                      input logic rw, input logic m2r, input logic pcs);
    RA1D = a1; RA2D = a2; WA3D = w;
    RegWriteD = rw; MemtoRegD = m2r; PCSrcD = pcs;
  endtask

  initial begin
    reset = 1'b1; PCNextF = 32'h0;
    stallF = 0; stallD = 0; flushD = 0; flushE = 0;
    setd(4'd0, 4'd0, 4'd0, 0, 0, 0);
    #3;
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_match", {27'd0, match}, 32'h0);
    chk("rst_pcwr", {31'd0, PCWrPendingF}, 32'h0);
    chk("rst_cnt", {stallCnt, flushCnt}, 32'h0);
    tick(); tick();
    reset = 1'b0;

    // validD rises on this edge; D inputs of this cycle are masked
    PCNextF = 32'h40;
    tick();
    chk("pcf_follow", PCF, 32'h40);

    // ALU forward: producer writes R3, consumer reads R3/R5
    setd(4'd0, 4'd0, 4'd3, 1, 0, 0);
    tick();
    setd(4'd3, 4'd5, 4'd6, 0, 0, 0);
    tick();
    chk("fwd_m_match", {27'd0, match}, 32'h08);
    chk("fwd_regwritem", {31'd0, RegWriteM}, 32'h1);
    setd(4'd3, 4'd8, 4'd9, 0, 0, 0);
    tick();
    chk("fwd_w_match", {27'd0, match}, 32'h02);
    chk("fwd_regwritew", {31'd0, RegWriteW}, 32'h1);

    // load-use
    setd(4'd10, 4'd11, 4'd2, 1, 1, 0);
    tick();
    setd(4'd12, 4'd2, 4'd13, 1, 0, 0);
    #1;
    chk("lu_match", {27'd0, match}, 32'h10);
    chk("lu_memtoreg", {31'd0, MemtoRegE}, 32'h1);
    stallD = 1; stallF = 1; flushE = 1; PCNextF = 32'h80;
    tick();
    chk("lu_pcf_hold", PCF, 32'h40);
    chk("lu_bubble", {27'd0, MemtoRegE, WA3E}, 32'h0);
    chk("lu_stallcnt", {28'd0, stallCnt}, 32'd1);
    chk("lu_flushcnt", {28'd0, flushCnt}, 32'd1);
    stallD = 0; stallF = 0; flushE = 0;
    tick();
    chk("lu_pcf_adv", PCF, 32'h80);
    chk("lu_w_match", {27'd0, match}, 32'h01);

    // branch: pending in D, E, M; flushD masks the following PCSrcD
    setd(4'd0, 4'd0, 4'd15, 0, 0, 1);
    #1;
    chk("br_pend_d", {31'd0, PCWrPendingF}, 32'h1);
    tick();
    PCSrcD = 0; flushD = 1;
    #1;
    chk("br_pend_e", {31'd0, PCWrPendingF}, 32'h1);
    tick();
    flushD = 0; PCSrcD = 1;
    #1;
    chk("br_pend_m", {31'd0, PCWrPendingF}, 32'h1);
    chk("br_flushcnt", {28'd0, flushCnt}, 32'd2);
    tick();
    PCSrcD = 0;
    #1;
    chk("br_pcsrcw", {31'd0, PCSrcW}, 32'h1);
    chk("br_masked", {31'd0, PCWrPendingF}, 32'h0);

    // R15 exclusion
    setd(4'hF, 4'hF, 4'hF, 1, 0, 0);
    tick(); tick(); tick();
    chk("r15_wa3", {20'd0, WA3E, WA3M, WA3W}, 32'hFFF);
    chk("r15_match", {27'd0, match}, 32'h0);

    // stall counter saturation
    stallD = 1;
    for (int i = 0; i < 13; i++) tick();
    chk("sat_stall_14", {28'd0, stallCnt}, 32'd14);
    for (int i = 0; i < 7; i++) tick();
    chk("sat_stall_15", {28'd0, stallCnt}, 32'd15);
    chk("sat_flush_idle", {28'd0, flushCnt}, 32'd2);
    stallD = 0; flushD = 1; flushE = 1;
    tick();
    chk("flush_both_1", {28'd0, flushCnt}, 32'd3);
    tick(); tick();
    chk("flush_both_3", {28'd0, flushCnt}, 32'd5);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_flush_15", {28'd0, flushCnt}, 32'd15);
    flushD = 0; flushE = 0;

    // asynchronous reset mid-run
    PCNextF = 32'h40;
    setd(4'd0, 4'd0, 4'd3, 1, 0, 0);
    tick(); tick(); tick();
    chk("pre_rst_state", {PCF[7:0], 7'd0, RegWriteM}, {8'h40, 8'h01});
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pcf", PCF, 32'h0);
    chk("arst_stage", {20'd0, WA3E, WA3M, WA3W}, 32'h0);
    chk("arst_ctl", {28'd0, RegWriteM, RegWriteW, MemtoRegE, PCSrcW}, 32'h0);
    chk("arst_match", {26'd0, PCWrPendingF, match}, 32'h0);
    chk("arst_cnt", {stallCnt, flushCnt}, 32'h0);
    #1;
    reset = 1'b0;
    PCNextF = 32'h44;
    tick();
    chk("post_rst_pcf", PCF, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
